// File: rtl/multi_phase_pwm_dt.sv
// Multi-phase half-bridge PWM generator. One shared sawtooth/triangle
// carrier, one duty per channel, a shared dead time, shadowed set-points
// that only update on carrier boundaries, and a latched zero-latency trip.
module multi_phase_pwm_dt #(
    parameter int N_CH = 3,
    parameter int CW   = 16,
    parameter int DTW  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [CW-1:0]        period,
    input  logic [N_CH*CW-1:0]   duty_cycle,
    input  logic [DTW-1:0]       dead_time,
    input  logic                 slope,
    input  logic                 load_sel,
    input  logic                 pwm_on,
    input  logic                 fault,
    input  logic                 fault_clr,
    output logic [CW-1:0]        counter,
    output logic                 f_zero,
    output logic                 f_period,
    output logic                 tripped,
    output logic [N_CH-1:0]      pwm_h,
    output logic [N_CH-1:0]      pwm_l
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DEAD = 2'd3
    } ch_state_t;

    localparam logic [CW-1:0]  CNT_ONE = CW'(1);
    localparam logic [DTW-1:0] DT_ONE  = DTW'(1);

    logic [CW-1:0]  counter_q, counter_d;
    logic           dir_up_q, dir_up_d;
    logic [CW-1:0]  period_sh_q, period_sh_d;
    logic [DTW-1:0] dead_sh_q, dead_sh_d;
    logic           tripped_q, tripped_d;

    logic           run;
    logic           shadow_load;
    logic           at_zero;
    logic           at_period;
    logic [DTW-1:0] dead_last;

    assign at_zero     = (counter_q == '0);
    assign at_period   = (counter_q == period_sh_q);
    assign run         = pwm_on & ~tripped_q & ~fault;
    // Set-points only move at the valley (or the peak in triangle mode when
    // requested), or freely while modulation is stopped.
    assign shadow_load = at_zero | (slope & load_sel & at_period) | ~run;
    // A dead time of zero still yields one cycle with both gates low.
    assign dead_last   = (dead_sh_q == '0) ? '0 : (dead_sh_q - DT_ONE);

    // Carrier next value: sawtooth wraps to 0, triangle reverses at the
    // extremes without repeating the turning-point sample.
    always_comb begin
        counter_d = counter_q;
        dir_up_d  = dir_up_q;
        if (period_sh_q == '0) begin
            counter_d = '0;
            dir_up_d  = 1'b1;
        end else if (!slope) begin
            dir_up_d  = 1'b1;
            counter_d = (counter_q >= period_sh_q) ? '0 : (counter_q + CNT_ONE);
        end else if (dir_up_q) begin
            if (counter_q >= period_sh_q) begin
                counter_d = counter_q - CNT_ONE;
                dir_up_d  = 1'b0;
            end else begin
                counter_d = counter_q + CNT_ONE;
            end
        end else begin
            if (at_zero) begin
                counter_d = CNT_ONE;
                dir_up_d  = 1'b1;
            end else begin
                counter_d = counter_q - CNT_ONE;
            end
        end
    end

    // Shared shadows and the trip latch (a fault beats a simultaneous clear).
    always_comb begin
        period_sh_d = shadow_load ? period : period_sh_q;
        dead_sh_d   = shadow_load ? dead_time : dead_sh_q;
        tripped_d   = tripped_q;
        if (fault) begin
            tripped_d = 1'b1;
        end else if (fault_clr) begin
            tripped_d = 1'b0;
        end
    end

    // Carrier, shared shadows and trip flag registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            counter_q   <= '0;
            dir_up_q    <= 1'b1;
            period_sh_q <= '0;
            dead_sh_q   <= '0;
            tripped_q   <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            dir_up_q    <= dir_up_d;
            period_sh_q <= period_sh_d;
            dead_sh_q   <= dead_sh_d;
            tripped_q   <= tripped_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CW-1:0]  duty_sh_q, duty_sh_d;
            ch_state_t      state_q, state_d;
            logic [DTW-1:0] dt_cnt_q, dt_cnt_d;
            logic           target;

            assign target = (counter_q < duty_sh_q);

            // Per-channel duty shadow follows the shared load strobe.
            always_comb begin
                duty_sh_d = shadow_load ? duty_cycle[gi*CW +: CW] : duty_sh_q;
            end

            // Gate FSM: every HIGH<->LOW swap passes through DEAD; stopping
            // modulation forces OFF ahead of anything else.
            always_comb begin
                state_d  = state_q;
                dt_cnt_d = dt_cnt_q;
                if (!run) begin
                    state_d  = ST_OFF;
                    dt_cnt_d = '0;
                end else begin
                    case (state_q)
                        ST_OFF: begin
                            state_d = target ? ST_HIGH : ST_LOW;
                        end
                        ST_HIGH: begin
                            if (!target) begin
                                state_d  = ST_DEAD;
                                dt_cnt_d = '0;
                            end
                        end
                        ST_LOW: begin
                            if (target) begin
                                state_d  = ST_DEAD;
                                dt_cnt_d = '0;
                            end
                        end
                        ST_DEAD: begin
                            if (dt_cnt_q >= dead_last) begin
                                state_d = target ? ST_HIGH : ST_LOW;
                            end else begin
                                dt_cnt_d = dt_cnt_q + DT_ONE;
                            end
                        end
                        default: begin
                            state_d = ST_OFF;
                        end
                    endcase
                end
            end

            // Per-channel registers.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    duty_sh_q <= '0;
                    state_q   <= ST_OFF;
                    dt_cnt_q  <= '0;
                end else begin
                    duty_sh_q <= duty_sh_d;
                    state_q   <= state_d;
                    dt_cnt_q  <= dt_cnt_d;
                end
            end

            // The raw fault input masks the gates combinationally.
            assign pwm_h[gi] = (state_q == ST_HIGH) & ~fault;
            assign pwm_l[gi] = (state_q == ST_LOW) & ~fault;
        end
    endgenerate

    assign counter  = counter_q;
    assign f_zero   = at_zero;
    assign f_period = at_period;
    assign tripped  = tripped_q;

endmodule

// File: tb/tb_multi_phase_pwm_dt.sv
// Self-checking bench for multi_phase_pwm_dt: frame tables of expected
// carrier/gate values, applied cycle by cycle through a scoreboard queue.
module tb_multi_phase_pwm_dt;

    localparam int N_CH = 3;
    localparam int CW   = 16;
    localparam int DTW  = 8;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [CW-1:0]        period;
    logic [N_CH*CW-1:0]   duty_cycle;
    logic [DTW-1:0]       dead_time;
    logic                 slope;
    logic                 load_sel;
    logic                 pwm_on;
    logic                 fault;
    logic                 fault_clr;
    logic [CW-1:0]        counter;
    logic                 f_zero;
    logic                 f_period;
    logic                 tripped;
    logic [N_CH-1:0]      pwm_h;
    logic [N_CH-1:0]      pwm_l;

    multi_phase_pwm_dt #(.N_CH(N_CH), .CW(CW), .DTW(DTW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .period     (period),
        .duty_cycle (duty_cycle),
        .dead_time  (dead_time),
        .slope      (slope),
        .load_sel   (load_sel),
        .pwm_on     (pwm_on),
        .fault      (fault),
        .fault_clr  (fault_clr),
        .counter    (counter),
        .f_zero     (f_zero),
        .f_period   (f_period),
        .tripped    (tripped),
        .pwm_h      (pwm_h),
        .pwm_l      (pwm_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        pwm_on;
        logic        fault;
        logic        fault_clr;
        int          c;
        logic [2:0]  h;
        logic [2:0]  l;
        logic        trip;
        logic        fz;
        logic        fp;
    } vec_t;

    typedef struct {
        int          c;
        logic [2:0]  h;
        logic [2:0]  l;
    } row_t;

    vec_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cur_period = 0;

    row_t frame_a[10];   // sawtooth p=9, duty=4, dead=2
    row_t frame_e[10];   // sawtooth p=9, duty=4, dead=0
    row_t frame_c[13];   // sawtooth p=9 after duty change to 7 at counter 5
    row_t frame_b[16];   // triangle p=8, duty {20,0,4}, dead=1
    row_t trans_b[6];    // triangle start-up after reset

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic check_out();
        vec_t v;
        v = sb.pop_front();
        n_vec++;
        if (counter !== v.c[CW-1:0] || pwm_h !== v.h || pwm_l !== v.l ||
            tripped !== v.trip || f_zero !== v.fz || f_period !== v.fp ||
            (pwm_h & pwm_l) !== 3'b000) begin
            n_miss++;
            $display("FAIL vec%0d: got cnt=%0d h=%b l=%b trip=%b fz=%b fp=%b, want cnt=%0d h=%b l=%b trip=%b fz=%b fp=%b",
                     n_vec, counter, pwm_h, pwm_l, tripped, f_zero, f_period,
                     v.c, v.h, v.l, v.trip, v.fz, v.fp);
        end else begin
            $display("vec%0d ok: cnt=%0d h=%b l=%b trip=%b", n_vec, counter, pwm_h, pwm_l, tripped);
        end
    endtask

    // Drive one cycle of control inputs, queue its expectation, clock, check.
    task automatic apply(input logic r, input logic on, input logic f, input logic fc,
                         input int c, input logic [2:0] h, input logic [2:0] l,
                         input logic t);
        vec_t v;
        v.rstn = r; v.pwm_on = on; v.fault = f; v.fault_clr = fc;
        v.c = c; v.h = h; v.l = l; v.trip = t;
        v.fz = (c == 0);
        v.fp = (c == (r ? cur_period : 0));
        rstn = r; pwm_on = on; fault = f; fault_clr = fc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic run_rows_a(input int reps);
        for (int k = 0; k < reps * 10; k++)
            apply(1, 1, 0, 0, frame_a[k % 10].c, frame_a[k % 10].h, frame_a[k % 10].l, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        frame_a = '{'{1, 3'd0, 3'd0}, '{2, 3'd0, 3'd0}, '{3, 3'd7, 3'd0}, '{4, 3'd7, 3'd0},
                    '{5, 3'd0, 3'd0}, '{6, 3'd0, 3'd0}, '{7, 3'd0, 3'd7}, '{8, 3'd0, 3'd7},
                    '{9, 3'd0, 3'd7}, '{0, 3'd0, 3'd7}};
        frame_e = '{'{1, 3'd0, 3'd0}, '{2, 3'd7, 3'd0}, '{3, 3'd7, 3'd0}, '{4, 3'd7, 3'd0},
                    '{5, 3'd0, 3'd0}, '{6, 3'd0, 3'd7}, '{7, 3'd0, 3'd7}, '{8, 3'd0, 3'd7},
                    '{9, 3'd0, 3'd7}, '{0, 3'd0, 3'd7}};
        frame_c = '{'{6, 3'd0, 3'd0}, '{7, 3'd0, 3'd7}, '{8, 3'd0, 3'd7}, '{9, 3'd0, 3'd7},
                    '{0, 3'd0, 3'd7}, '{1, 3'd0, 3'd0}, '{2, 3'd0, 3'd0}, '{3, 3'd7, 3'd0},
                    '{4, 3'd7, 3'd0}, '{5, 3'd7, 3'd0}, '{6, 3'd7, 3'd0}, '{7, 3'd7, 3'd0},
                    '{8, 3'd0, 3'd0}};
        trans_b = '{'{0, 3'd0, 3'd7}, '{1, 3'd0, 3'd2}, '{2, 3'd5, 3'd2}, '{3, 3'd5, 3'd2},
                    '{4, 3'd5, 3'd2}, '{5, 3'd4, 3'd2}};
        frame_b = '{'{6, 3'd4, 3'd3}, '{7, 3'd4, 3'd3}, '{8, 3'd4, 3'd3}, '{7, 3'd4, 3'd3},
                    '{6, 3'd4, 3'd3}, '{5, 3'd4, 3'd3}, '{4, 3'd4, 3'd3}, '{3, 3'd4, 3'd3},
                    '{2, 3'd4, 3'd2}, '{1, 3'd5, 3'd2}, '{0, 3'd5, 3'd2}, '{1, 3'd5, 3'd2},
                    '{2, 3'd5, 3'd2}, '{3, 3'd5, 3'd2}, '{4, 3'd5, 3'd2}, '{5, 3'd4, 3'd2}};

        rstn = 1'b0; pwm_on = 1'b1; fault = 1'b0; fault_clr = 1'b0;
        slope = 1'b0; load_sel = 1'b0;
        period = 16'd9; cur_period = 9;
        duty_cycle = {16'd4, 16'd4, 16'd4};
        dead_time = 8'd2;

        // Reset state, then sawtooth steady state with dead=2.
        apply(0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
        apply(0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 0, 3'd0, 3'd7, 0);
        run_rows_a(2);

        // Duty 4 -> 7 while the counter sits at 5: takes effect after next zero.
        for (int k = 0; k < 5; k++)
            apply(1, 1, 0, 0, frame_a[k].c, frame_a[k].h, frame_a[k].l, 0);
        duty_cycle = {16'd7, 16'd7, 16'd7};
        for (int k = 0; k < 13; k++)
            apply(1, 1, 0, 0, frame_c[k].c, frame_c[k].h, frame_c[k].l, 0);
        apply(1, 1, 0, 0, 9, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 0, 3'd0, 3'd7, 0);
        apply(1, 1, 0, 0, 1, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 2, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 3, 3'd7, 3'd0, 0);

        // Fault while high side is on: immediate mask, then latch and clear.
        fault = 1'b1;
        #1;
        n_vec++;
        if (pwm_h !== 3'd0 || pwm_l !== 3'd0 || tripped !== 1'b0) begin
            n_miss++;
            $display("FAIL fault_mask: got h=%b l=%b trip=%b, want h=000 l=000 trip=0",
                     pwm_h, pwm_l, tripped);
        end else begin
            $display("vec%0d ok: fault mask h=%b l=%b", n_vec, pwm_h, pwm_l);
        end
        apply(1, 1, 1, 0, 4, 3'd0, 3'd0, 1);
        apply(1, 1, 1, 1, 5, 3'd0, 3'd0, 1);
        apply(1, 1, 0, 1, 6, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 7, 3'd7, 3'd0, 0);
        apply(1, 1, 0, 0, 8, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 9, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 0, 3'd0, 3'd7, 0);

        // Dead time 0 still gives one-cycle dead windows.
        duty_cycle = {16'd4, 16'd4, 16'd4};
        dead_time = 8'd0;
        apply(0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
        apply(0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 0, 3'd0, 3'd7, 0);
        for (int k = 0; k < 20; k++)
            apply(1, 1, 0, 0, frame_e[k % 10].c, frame_e[k % 10].h, frame_e[k % 10].l, 0);

        // pwm_on drop, resume, then reset in the middle of a period.
        apply(1, 1, 0, 0, 1, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 2, 3'd7, 3'd0, 0);
        apply(1, 0, 0, 0, 3, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 4, 3'd7, 3'd0, 0);
        apply(1, 1, 0, 0, 5, 3'd0, 3'd0, 0);
        apply(0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
        apply(1, 1, 0, 0, 0, 3'd0, 3'd7, 0);

        // Triangle carrier, duties {ch2=20, ch1=0, ch0=4}, dead=1.
        slope = 1'b1; load_sel = 1'b1;
        period = 16'd8; cur_period = 8;
        duty_cycle = {16'd20, 16'd0, 16'd4};
        dead_time = 8'd1;
        apply(0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
        apply(0, 1, 0, 0, 0, 3'd0, 3'd0, 0);
        for (int k = 0; k < 6; k++)
            apply(1, 1, 0, 0, trans_b[k].c, trans_b[k].h, trans_b[k].l, 0);
        for (int k = 0; k < 32; k++)
            apply(1, 1, 0, 0, frame_b[k % 16].c, frame_b[k % 16].h, frame_b[k % 16].l, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
